// File: rtl/llm_pkg.sv
// Shared helpers for the model datapath: clamped signed addition and
// nonzero-lane counting, written once for any entry width up to MAX_WIDTH.
package llm_pkg;

    localparam int MAX_WIDTH = 32;
    localparam int MAX_LANES = 64;
    localparam int MAX_FLAT  = MAX_WIDTH * MAX_LANES;

    // Operands arrive sign-extended to MAX_WIDTH; the caller keeps the low
    // `width` bits of the result, which always fit after the clamp.
    function automatic logic [MAX_WIDTH-1:0] sat_add(
        input logic signed [MAX_WIDTH-1:0] a,
        input logic signed [MAX_WIDTH-1:0] b,
        input int                          width
    );
        logic signed [MAX_WIDTH:0] sum;
        logic signed [MAX_WIDTH:0] one;
        logic signed [MAX_WIDTH:0] maxV;
        logic signed [MAX_WIDTH:0] minV;
        logic signed [MAX_WIDTH:0] res;
        sum    = {a[MAX_WIDTH-1], a} + {b[MAX_WIDTH-1], b};
        one    = '0;
        one[0] = 1'b1;
        maxV   = (one <<< (width - 1)) - one;
        minV   = -(one <<< (width - 1));
        if (sum > maxV) begin
            res = maxV;
        end else if (sum < minV) begin
            res = minV;
        end else begin
            res = sum;
        end
        return res[MAX_WIDTH-1:0];
    endfunction

    function automatic int popcount_nonzero(
        input logic [MAX_FLAT-1:0] flat,
        input int                  lanes,
        input int                  width
    );
        int   count;
        logic nz;
        count = 0;
        for (int i = 0; i < MAX_LANES; i++) begin
            nz = 1'b0;
            for (int j = 0; j < MAX_WIDTH; j++) begin
                if (i < lanes && j < width) begin
                    nz = nz | flat[i*width + j];
                end
            end
            if (nz) begin
                count++;
            end
        end
        return count;
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Small synchronous FIFO with an extra pointer bit separating full from empty.
// Ready depends only on reset and fullness, never on the incoming valid.
module fifo_sync #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wrPtr_q, wrPtr_d;
    logic [AW:0]      rdPtr_q, rdPtr_d;
    logic             full;
    logic             wrFire;

    assign empty_o    = (wrPtr_q == rdPtr_q);
    assign full       = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign wr_ready_o = !rst_i && !full;
    assign wrFire     = wr_valid_i && wr_ready_o;
    assign rd_data_o  = mem_q[rdPtr_q[AW-1:0]];

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (wrFire) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (rd_en_i) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk_i) begin
        if (wrFire) begin
            mem_q[wrPtr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/gather.sv
// Joins the large and small operand streams beat-for-beat, adds them lane-wise
// with saturation, and registers the dense result; also counts outlier lanes.
module gather
    import llm_pkg::*;
#(
    parameter int IN_WIDTH       = 16,
    parameter int IN_FRAC_WIDTH  = 0,
    parameter int IN_SIZE        = 4,
    parameter int IN_PARALLELISM = 1,
    parameter int FIFO_DEPTH     = 2,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [IN_SIZE*IN_PARALLELISM*IN_WIDTH-1:0] data_in_large,
    input  logic                                      data_in_large_valid,
    output logic                                      data_in_large_ready,
    input  logic [IN_SIZE*IN_PARALLELISM*IN_WIDTH-1:0] data_in_small,
    input  logic                                      data_in_small_valid,
    output logic                                      data_in_small_ready,
    output logic [IN_SIZE*IN_PARALLELISM*IN_WIDTH-1:0] data_out,
    output logic                                      data_out_valid,
    input  logic                                      data_out_ready,
    output logic [COUNT_WIDTH-1:0]                    outlier_count
);

    localparam int N    = IN_SIZE * IN_PARALLELISM;
    localparam int FLAT = N * IN_WIDTH;
    localparam int CW2  = COUNT_WIDTH + 32;

    if (IN_FRAC_WIDTH < 0 || IN_FRAC_WIDTH >= IN_WIDTH || IN_WIDTH > MAX_WIDTH ||
        N > MAX_LANES || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gParamCheck
        $error("gather: unsupported parameterisation");
    end

    logic [FLAT-1:0]        largeHead, smallHead;
    logic                   largeEmpty, smallEmpty;
    logic                   joinFire, largeWrite;
    logic [FLAT-1:0]        sumLanes;
    logic [FLAT-1:0]        dataOut_q;
    logic                   dataOutValid_q;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [CW2-1:0]         countWide;
    int                     laneHits;

    fifo_sync #(.WIDTH(FLAT), .DEPTH(FIFO_DEPTH)) u_largeFifo (
        .clk_i      (clk),
        .rst_i      (rst),
        .wr_valid_i (data_in_large_valid),
        .wr_ready_o (data_in_large_ready),
        .wr_data_i  (data_in_large),
        .rd_en_i    (joinFire),
        .rd_data_o  (largeHead),
        .empty_o    (largeEmpty)
    );

    fifo_sync #(.WIDTH(FLAT), .DEPTH(FIFO_DEPTH)) u_smallFifo (
        .clk_i      (clk),
        .rst_i      (rst),
        .wr_valid_i (data_in_small_valid),
        .wr_ready_o (data_in_small_ready),
        .wr_data_i  (data_in_small),
        .rd_en_i    (joinFire),
        .rd_data_o  (smallHead),
        .empty_o    (smallEmpty)
    );

    // Both FIFOs pop together so beat k of each stream always pairs up.
    assign largeWrite = data_in_large_valid && data_in_large_ready;
    assign joinFire   = !largeEmpty && !smallEmpty && (!dataOutValid_q || data_out_ready);

    always_comb begin
        sumLanes = '0;
        for (int i = 0; i < N; i++) begin
            sumLanes[i*IN_WIDTH +: IN_WIDTH] = IN_WIDTH'(sat_add(
                MAX_WIDTH'($signed(largeHead[i*IN_WIDTH +: IN_WIDTH])),
                MAX_WIDTH'($signed(smallHead[i*IN_WIDTH +: IN_WIDTH])),
                IN_WIDTH));
        end
    end

    // Widened sum lets a single compare detect saturation of the profiling counter.
    always_comb begin
        laneHits  = popcount_nonzero(MAX_FLAT'(data_in_large), N, IN_WIDTH);
        countWide = CW2'(count_q) + CW2'(unsigned'(laneHits));
        count_d   = count_q;
        if (largeWrite) begin
            if (countWide > CW2'({COUNT_WIDTH{1'b1}})) begin
                count_d = '1;
            end else begin
                count_d = countWide[COUNT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dataOut_q      <= '0;
            dataOutValid_q <= 1'b0;
            count_q        <= '0;
        end else begin
            if (joinFire) begin
                dataOut_q      <= sumLanes;
                dataOutValid_q <= 1'b1;
            end else if (data_out_ready) begin
                dataOutValid_q <= 1'b0;
            end
            count_q <= count_d;
        end
    end

    assign data_out       = dataOut_q;
    assign data_out_valid = dataOutValid_q;
    assign outlier_count  = count_q;

endmodule

// File: tb/tb_gather.sv
// Randomized and directed bench for gather, compared every cycle against a
// queue-based reference model of the recombine stage.
module tb_gather;

    localparam int W    = 16;
    localparam int N    = 4;
    localparam int D    = 2;
    localparam int CW   = 4;
    localparam int FW   = N * W;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] dataInLarge, dataInSmall, dataOut;
    logic          largeValid, largeReady, smallValid, smallReady;
    logic          outValid, outReady;
    logic [CW-1:0] outlierCount;

    always #5 clk = ~clk;

    gather #(
        .IN_WIDTH(W), .IN_FRAC_WIDTH(0), .IN_SIZE(N), .IN_PARALLELISM(1),
        .FIFO_DEPTH(D), .COUNT_WIDTH(CW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .data_in_large       (dataInLarge),
        .data_in_large_valid (largeValid),
        .data_in_large_ready (largeReady),
        .data_in_small       (dataInSmall),
        .data_in_small_valid (smallValid),
        .data_in_small_ready (smallReady),
        .data_out            (dataOut),
        .data_out_valid      (outValid),
        .data_out_ready      (outReady),
        .outlier_count       (outlierCount)
    );

    int checkCount = 0;
    int passCount  = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: beats as queues, sums by plain integer arithmetic.
    logic [FW-1:0] qL[$];
    logic [FW-1:0] qS[$];
    logic          mValid;
    logic [FW-1:0] mData;
    int            mCount;
    bit            mLive = 1'b0;

    function automatic logic [FW-1:0] refSum(input logic [FW-1:0] l, input logic [FW-1:0] s);
        logic [FW-1:0] r;
        int a, b, t;
        for (int i = 0; i < N; i++) begin
            a = int'($signed(l[i*W +: W]));
            b = int'($signed(s[i*W +: W]));
            t = a + b;
            if (t > 32767) t = 32767;
            if (t < -32768) t = -32768;
            r[i*W +: W] = t[W-1:0];
        end
        return r;
    endfunction

    function automatic int nonzeroLanes(input logic [FW-1:0] l);
        int c;
        c = 0;
        for (int i = 0; i < N; i++) begin
            if (l[i*W +: W] != '0) c++;
        end
        return c;
    endfunction

    function automatic logic [FW-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [FW-1:0] r;
        r[0*W +: W] = a[W-1:0];
        r[1*W +: W] = b[W-1:0];
        r[2*W +: W] = c[W-1:0];
        r[3*W +: W] = d[W-1:0];
        return r;
    endfunction

    always @(posedge clk) begin : modelStep
        bit lAcc, sAcc, doJoin;
        if (rst) begin
            qL.delete();
            qS.delete();
            mValid = 1'b0;
            mData  = '0;
            mCount = 0;
            mLive  = 1'b1;
        end else if (mLive) begin
            lAcc   = largeValid && (qL.size() < D);
            sAcc   = smallValid && (qS.size() < D);
            doJoin = (qL.size() > 0) && (qS.size() > 0) && (!mValid || outReady);
            if (doJoin) begin
                mData  = refSum(qL.pop_front(), qS.pop_front());
                mValid = 1'b1;
            end else if (outReady) begin
                mValid = 1'b0;
            end
            if (lAcc) begin
                qL.push_back(dataInLarge);
                mCount = mCount + nonzeroLanes(dataInLarge);
                if (mCount > CMAX) mCount = CMAX;
            end
            if (sAcc) begin
                qS.push_back(dataInSmall);
            end
        end
    end

    // Every cycle the model is live, all outputs are compared.
    always @(negedge clk) begin
        if (mLive) begin
            checkOutput("data_out_valid", 64'(outValid), 64'(mValid));
            checkOutput("data_out", 64'(dataOut), 64'(mData));
            checkOutput("outlier_count", 64'(outlierCount), 64'(mCount));
            checkOutput("large_ready", 64'(largeReady), 64'(!rst && (qL.size() < D)));
            checkOutput("small_ready", 64'(smallReady), 64'(!rst && (qS.size() < D)));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic lv, input logic [FW-1:0] l,
                                 input logic sv, input logic [FW-1:0] s, input logic ordy);
        largeValid  = lv;
        dataInLarge = l;
        smallValid  = sv;
        dataInSmall = s;
        outReady    = ordy;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic logic [W-1:0] randLane(input bit allowZero);
        int v;
        case ($urandom_range(0, 3))
            0: v = allowZero ? 0 : 1;
            1: v = int'($urandom_range(0, 255)) - 128;
            2: case ($urandom_range(0, 3))
                   0: v = 32767;
                   1: v = -32768;
                   2: v = 30000;
                   default: v = -30000;
               endcase
            default: v = int'($urandom_range(0, 65535));
        endcase
        return v[W-1:0];
    endfunction

    initial begin
        int outs;
        int stallLeft;
        logic [FW-1:0] l, s;
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        step();

        // Disjoint recombine and minimum latency
        doReset();
        checkOutput("reset valid", 64'(outValid), 64'd0);
        checkOutput("reset data", 64'(dataOut), 64'd0);
        applyStimulus(1'b1, pack4(0, 200, 0, 0), 1'b1, pack4(5, 0, -3, 7), 1'b1);
        step();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("latency valid low", 64'(outValid), 64'd0);
        step();
        checkOutput("disjoint valid", 64'(outValid), 64'd1);
        checkOutput("disjoint data", 64'(dataOut), 64'h0007_FFFD_00C8_0005);
        checkOutput("disjoint count", 64'(outlierCount), 64'd1);

        // Saturation both directions
        doReset();
        applyStimulus(1'b1, pack4(30000, -30000, 0, 0), 1'b1, pack4(10000, -10000, 0, 0), 1'b1);
        step();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        step();
        checkOutput("saturate data", 64'(dataOut), 64'h0000_0000_8000_7FFF);

        // Skew: large runs two beats ahead
        doReset();
        applyStimulus(1'b1, pack4(1, 2, 3, 4), 1'b0, '0, 1'b1);
        step();
        applyStimulus(1'b1, pack4(10, 20, 30, 40), 1'b0, '0, 1'b1);
        step();
        checkOutput("skew large_ready", 64'(largeReady), 64'd0);
        checkOutput("skew valid", 64'(outValid), 64'd0);
        applyStimulus(1'b1, pack4(9, 9, 9, 9), 1'b0, '0, 1'b1);
        step();
        applyStimulus(1'b0, '0, 1'b1, pack4(100, 100, 100, 100), 1'b1);
        step();
        applyStimulus(1'b0, '0, 1'b1, pack4(1000, 1000, 1000, 1000), 1'b1);
        step();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("skew beat0", 64'(dataOut), 64'(pack4(101, 102, 103, 104)));
        step();
        checkOutput("skew beat1", 64'(dataOut), 64'(pack4(1010, 1020, 1030, 1040)));
        checkOutput("skew count", 64'(outlierCount), 64'd8);

        // Counter saturation
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, pack4(1, -1, 7, 300), 1'b1, '0, 1'b1);
            step();
        end
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        step();
        checkOutput("count saturate", 64'(outlierCount), 64'd15);

        // Reset mid-stream with full FIFOs and a stalled output
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, pack4(i + 1, 0, 0, 0), 1'b1, pack4(0, i, 0, 0), 1'b0);
            step();
        end
        checkOutput("stall valid", 64'(outValid), 64'd1);
        checkOutput("stall full", 64'(largeReady), 64'd0);
        rst = 1'b1;
        step();
        checkOutput("midrst valid", 64'(outValid), 64'd0);
        checkOutput("midrst ready", 64'(smallReady), 64'd0);
        checkOutput("midrst count", 64'(outlierCount), 64'd0);
        rst = 1'b0;
        applyStimulus(1'b1, pack4(3, 0, 0, 0), 1'b1, pack4(0, 4, 0, 0), 1'b1);
        step();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        outs = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (outValid) outs++;
        end
        checkOutput("post-reset outputs", 64'(outs), 64'd1);

        // Randomized traffic with stalls, skew and occasional resets
        stallLeft = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                l[i*W +: W] = ($urandom_range(0, 1) == 0) ? '0 : randLane(1'b0);
                s[i*W +: W] = randLane(1'b1);
            end
            rst = ($urandom_range(0, 299) == 0);
            if (stallLeft > 0) begin
                stallLeft--;
                outReady = 1'b0;
            end else if ($urandom_range(0, 19) == 0) begin
                stallLeft = $urandom_range(1, 8);
                outReady  = 1'b0;
            end else begin
                outReady = ($urandom_range(0, 3) != 0);
            end
            applyStimulus($urandom_range(0, 3) != 0, l, $urandom_range(0, 3) != 0, s, outReady);
            step();
        end

        rst = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        step();
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
